// File: rtl/matvec_pkg.sv
// matvec_sched shared types and sizing helpers.
// Used by the scheduler, its datapath and the bench.
package matvec_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   function automatic int mv_latency(input int c);
      return $clog2(c) + 1;
   endfunction

   function automatic int mv_wy(input int w_x, input int w_k, input int c);
      return w_x + w_k + $clog2(c);
   endfunction

endpackage

// File: rtl/matvec_mul.sv
// R-row signed matrix-vector product, one tile per enabled cycle.
// Registered products feed a registered adder tree; latency $clog2(C)+1.
module matvec_mul
   import matvec_pkg::*;
#(
   parameter  int R   = 2,
   parameter  int C   = 5,
   parameter  int W_X = 3,
   parameter  int W_K = 4,
   localparam int W_Y = mv_wy(W_X, W_K, C)
) (
   input  logic               clk,
   input  logic               cen,
   input  logic [C*W_X-1:0]   x,
   input  logic [R*C*W_K-1:0] k,
   output logic [R*W_Y-1:0]   y
);

   localparam int L  = $clog2(C);
   localparam int NP = 1 << L;
   localparam int NN = 2 * NP - 1;

   typedef logic signed [W_Y-1:0] acc_t;

   acc_t leaf_d [R][NP];
   acc_t tree_q [R][NN];

   // products of one tile, zero-padded up to a power of two
   always_comb begin
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < NP; c++) begin
            leaf_d[r][c] = '0;
         end
         for (int c = 0; c < C; c++) begin
            leaf_d[r][c] = acc_t'($signed(x[c*W_X +: W_X]) *
                                  $signed(k[(r*C+c)*W_K +: W_K]));
         end
      end
   end

   // heap-ordered tree: leaves at NP-1.., node i sums 2i+1 and 2i+2
   always_ff @(posedge clk) begin
      if (cen) begin
         for (int r = 0; r < R; r++) begin
            for (int i = 0; i < NP - 1; i++) begin
               tree_q[r][i] <= tree_q[r][2*i+1] + tree_q[r][2*i+2];
            end
            for (int c = 0; c < NP; c++) begin
               tree_q[r][NP-1+c] <= leaf_d[r][c];
            end
         end
      end
   end

   // tree roots are the row results
   always_comb begin
      y = '0;
      for (int r = 0; r < R; r++) begin
         y[r*W_Y +: W_Y] = tree_q[r][0];
      end
   end

endmodule

// File: rtl/matvec_sched.sv
// Job scheduler around matvec_mul: streams T weight tiles per vector
// and returns R results per beat, freezing the datapath on backpressure.
module matvec_sched
   import matvec_pkg::*;
#(
   parameter  int R   = 2,
   parameter  int C   = 5,
   parameter  int W_X = 3,
   parameter  int W_K = 4,
   parameter  int M   = 8,
   localparam int T   = M / R,
   localparam int W_A = (T > 1) ? $clog2(T) : 1,
   localparam int W_Y = mv_wy(W_X, W_K, C),
   localparam int LAT = mv_latency(C)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [C*W_X-1:0]   s_x,
   output logic               w_en,
   output logic [W_A-1:0]     w_addr,
   input  logic [R*C*W_K-1:0] w_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [R*W_Y-1:0]   m_data,
   output logic [W_A-1:0]     m_idx,
   output logic               m_last
);

   typedef struct packed {
      logic           vld;
      logic [W_A-1:0] idx;
      logic           last;
   } tag_t;

   state_e           state_q;
   logic             s_ready_q;
   logic [W_A-1:0]   cnt_q;
   logic [C*W_X-1:0] x_q;
   tag_t             tag_q [LAT+1];

   logic cen;
   logic issue;
   logic cnt_last;

   assign cen      = !(m_valid && !m_ready);
   assign issue    = (state_q == RUN) && cen;
   assign cnt_last = (cnt_q == W_A'(T - 1));

   assign s_ready = s_ready_q;
   assign w_en    = issue;
   assign w_addr  = cnt_q;
   assign m_valid = tag_q[LAT].vld;
   assign m_idx   = tag_q[LAT].idx;
   assign m_last  = tag_q[LAT].last;

   // job FSM: accept vector, issue tiles, wait for the last beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         s_ready_q <= 1'b1;
         cnt_q     <= '0;
         x_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (s_valid) begin
                  x_q       <= s_x;
                  cnt_q     <= '0;
                  s_ready_q <= 1'b0;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               if (cen) begin
                  if (cnt_last) begin
                     state_q <= DRAIN;
                  end else begin
                     cnt_q <= cnt_q + W_A'(1);
                  end
               end
            end
            DRAIN: begin
               if (m_valid && m_ready && m_last) begin
                  s_ready_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // tag shift register tracks each issued tile through the datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i <= LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else if (cen) begin
         tag_q[0] <= issue ? tag_t'{vld: 1'b1, idx: cnt_q, last: cnt_last}
                           : tag_t'('0);
         for (int i = 1; i <= LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   matvec_mul #(
      .R   (R),
      .C   (C),
      .W_X (W_X),
      .W_K (W_K)
   ) u_mul (
      .clk (clk),
      .cen (cen),
      .x   (x_q),
      .k   (w_data),
      .y   (m_data)
   );

endmodule

// File: tb/tb_matvec_sched.sv
// Self-checking bench for matvec_sched with a scoreboard of expected
// beats and a synchronous weight memory model.
module tb_matvec_sched;
   import matvec_pkg::*;

   localparam int R   = 2;
   localparam int C   = 5;
   localparam int W_X = 3;
   localparam int W_K = 4;
   localparam int M   = 8;
   localparam int T   = M / R;
   localparam int W_A = (T > 1) ? $clog2(T) : 1;
   localparam int W_Y = mv_wy(W_X, W_K, C);
   localparam int LAT = mv_latency(C);
   localparam int VW  = 4 + 2 * W_A + R * W_Y;

   typedef struct {
      logic [R*W_Y-1:0] d;
      logic [W_A-1:0]   idx;
      logic             last;
   } beat_t;

   logic               clk = 1'b0;
   logic               rstn;
   logic               s_valid;
   logic               s_ready;
   logic [C*W_X-1:0]   s_x;
   logic               w_en;
   logic [W_A-1:0]     w_addr;
   logic [R*C*W_K-1:0] w_data;
   logic               m_valid;
   logic               m_ready;
   logic [R*W_Y-1:0]   m_data;
   logic [W_A-1:0]     m_idx;
   logic               m_last;

   logic [R*C*W_K-1:0] mem [T];
   beat_t              sbq [$];
   int                 checks = 0;
   int                 errors = 0;
   int                 beats  = 0;

   matvec_sched #(
      .R(R), .C(C), .W_X(W_X), .W_K(W_K), .M(M)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_x     (s_x),
      .w_en    (w_en),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_idx   (m_idx),
      .m_last  (m_last)
   );

   always #5 clk = ~clk;

   // synchronous weight memory, output held while not enabled
   always @(posedge clk) begin
      if (w_en) w_data <= mem[w_addr];
   end

   // scoreboard: every accepted beat must match the next expected one
   always @(negedge clk) begin
      beat_t e;
      if (rstn && m_valid && m_ready) begin
         beats++;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got idx %0d data %h, expected none",
                     m_idx, m_data);
         end else begin
            e = sbq.pop_front();
            if (m_data !== e.d || m_idx !== e.idx || m_last !== e.last) begin
               errors++;
               $display("FAIL beat: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                        m_data, m_idx, m_last, e.d, e.idx, e.last);
            end
         end
      end
   end

   function automatic logic [C*W_X-1:0] fill_x(input int v);
      logic [C*W_X-1:0] p;
      for (int c = 0; c < C; c++) p[c*W_X +: W_X] = W_X'(v);
      return p;
   endfunction

   function automatic logic [R*C*W_K-1:0] fill_k(input int v);
      logic [R*C*W_K-1:0] p;
      for (int e = 0; e < R*C; e++) p[e*W_K +: W_K] = W_K'(v);
      return p;
   endfunction

   function automatic logic [R*W_Y-1:0] rep_y(input int v);
      logic [R*W_Y-1:0] p;
      for (int r = 0; r < R; r++) p[r*W_Y +: W_Y] = W_Y'(v);
      return p;
   endfunction

   function automatic logic [R*W_Y-1:0] ref_tile(
      input logic [C*W_X-1:0] x, input logic [R*C*W_K-1:0] k);
      logic [R*W_Y-1:0] p;
      int s;
      for (int r = 0; r < R; r++) begin
         s = 0;
         for (int c = 0; c < C; c++) begin
            s += int'($signed(x[c*W_X +: W_X])) *
                 int'($signed(k[(r*C+c)*W_K +: W_K]));
         end
         p[r*W_Y +: W_Y] = W_Y'(s);
      end
      return p;
   endfunction

   task automatic push_job(input logic [C*W_X-1:0] x);
      for (int t = 0; t < T; t++) begin
         sbq.push_back(beat_t'{d: ref_tile(x, mem[t]), idx: W_A'(t),
                               last: (t == T - 1)});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // caller is idle at posedge+1; returns at posedge+1 of cycle 1
   task automatic start_job(input logic [C*W_X-1:0] x);
      s_valid = 1'b1;
      s_x     = x;
      push_job(x);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input int pct, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
         m_ready = ($urandom_range(0, 99) < pct);
         tick();
      end
      m_ready = 1'b1;
   endtask

   task automatic test_reset();
      logic [2*W_A+3:0] o_vec;
      rstn = 1'b0; s_valid = 1'b0; s_x = '0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      for (int p = 0; p < 2; p++) begin
         @(negedge clk);
         o_vec = {s_ready, w_en, w_addr, m_valid, m_idx, m_last};
         checks++;
         if (o_vec !== {1'b1, 1'b0, W_A'(0), 1'b0, W_A'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_p%0d: got %b expected %b", p, o_vec,
                     {1'b1, 1'b0, W_A'(0), 1'b0, W_A'(0), 1'b0});
         end
         @(posedge clk);
         #1 rstn = 1'b1;
      end
   endtask

   task automatic test_single();
      logic [VW-1:0] o_vec, e_vec;
      logic ev, ew;
      int bi;
      for (int t = 0; t < T; t++) mem[t] = fill_k(t - 2);
      start_job(fill_x(1));
      for (int k = 1; k <= 2 + LAT + T; k++) begin
         @(negedge clk);
         ew = (k <= T);
         ev = (k >= 2 + LAT) && (k < 2 + LAT + T);
         bi = k - 2 - LAT;
         e_vec = {(k == 2 + LAT + T), ew, ew ? W_A'(k - 1) : W_A'(0),
                  ev, ev ? W_A'(bi) : W_A'(0), ev && (bi == T - 1),
                  ev ? rep_y(5 * (bi - 2)) : {R*W_Y{1'b0}}};
         o_vec = {s_ready, w_en, ew ? w_addr : W_A'(0),
                  m_valid, ev ? m_idx : W_A'(0), ev ? m_last : 1'b0,
                  ev ? m_data : {R*W_Y{1'b0}}};
         checks++;
         if (o_vec !== e_vec) begin
            errors++;
            $display("FAIL single_c%0d: got %h expected %h", k, o_vec, e_vec);
         end
         tick();
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL single_left: got %0d pending beats expected 0", sbq.size());
      end
   endtask

   task automatic test_extremes();
      int xv [2] = '{-4, 3};
      int ev [2] = '{160, -120};
      int n;
      for (int j = 0; j < 2; j++) begin
         for (int t = 0; t < T; t++) mem[t] = fill_k(-8);
         n = 0;
         start_job(fill_x(xv[j]));
         for (int i = 0; i < 30 && !s_ready; i++) begin
            @(negedge clk);
            if (m_valid) begin
               n++;
               checks++;
               if (m_data !== rep_y(ev[j])) begin
                  errors++;
                  $display("FAIL extreme_%0d: got %h expected %h", j, m_data,
                           rep_y(ev[j]));
               end
            end
            tick();
         end
         checks++;
         if (!s_ready || n != T) begin
            errors++;
            $display("FAIL extreme_count_%0d: got ready=%b beats=%0d expected 1 %0d",
                     j, s_ready, n, T);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [VW-1:0] o_vec, e_vec;
      logic ev, ew;
      int bi;
      for (int t = 0; t < T; t++) mem[t] = fill_k(t - 2);
      start_job(fill_x(2));
      for (int k = 1; k <= 13; k++) begin
         m_ready = !(k >= 7 && k <= 9);
         @(negedge clk);
         ew = (k <= T);
         ev = (k >= 6) && (k <= 12);
         bi = (k <= 6) ? 0 : (k <= 10) ? 1 : k - 9;
         e_vec = {(k == 13), ew, ew ? W_A'(k - 1) : W_A'(0),
                  ev, ev ? W_A'(bi) : W_A'(0), ev && (bi == T - 1),
                  ev ? rep_y(10 * (bi - 2)) : {R*W_Y{1'b0}}};
         o_vec = {s_ready, w_en, ew ? w_addr : W_A'(0),
                  m_valid, ev ? m_idx : W_A'(0), ev ? m_last : 1'b0,
                  ev ? m_data : {R*W_Y{1'b0}}};
         checks++;
         if (o_vec !== e_vec) begin
            errors++;
            $display("FAIL stall_c%0d: got %h expected %h", k, o_vec, e_vec);
         end
         tick();
      end
      m_ready = 1'b1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL stall_left: got %0d pending beats expected 0", sbq.size());
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      for (int t = 0; t < T; t++) mem[t] = fill_k(t - 2);
      s_valid = 1'b1;
      s_x     = fill_x(1);
      push_job(fill_x(1));
      tick();
      s_x = fill_x(-1);
      for (int k = 1; k <= 1 + LAT + T; k++) begin
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_c%0d: got s_ready=%b expected 0", k, s_ready);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_free: got s_ready=%b expected 1", s_ready);
      end
      push_job(fill_x(-1));
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, w_en, w_addr} !== {1'b0, 1'b1, W_A'(0)}) begin
         errors++;
         $display("FAIL b2b_accept: got %b expected %b", {s_ready, w_en, w_addr},
                  {1'b0, 1'b1, W_A'(0)});
      end
      tick();
      wait_idle(40, 100, ok);
      checks++;
      if (!ok || sbq.size() != 0) begin
         errors++;
         $display("FAIL b2b_done: got idle=%b pending=%0d expected 1 0", ok, sbq.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int bad;
      for (int t = 0; t < T; t++) mem[t] = fill_k(t - 2);
      start_job(fill_x(1));
      repeat (4) tick();
      rstn = 1'b0;
      sbq.delete();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if ({m_valid, s_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_low_%0d: got %b expected 01", k, {m_valid, s_ready});
         end
         tick();
      end
      rstn = 1'b1;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (m_valid !== 1'b0 || s_ready !== 1'b1) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rstmid_stale: got %0d bad cycles expected 0", bad);
      end
      start_job(fill_x(-2));
      wait_idle(40, 100, ok);
      checks++;
      if (!ok || sbq.size() != 0) begin
         errors++;
         $display("FAIL rstmid_job: got idle=%b pending=%0d expected 1 0", ok, sbq.size());
      end
   endtask

   task automatic test_random();
      bit ok;
      int b0;
      logic [C*W_X-1:0] x;
      for (int j = 0; j < 200; j++) begin
         for (int t = 0; t < T; t++) begin
            for (int e = 0; e < R*C; e++) mem[t][e*W_K +: W_K] = W_K'($urandom);
         end
         for (int c = 0; c < C; c++) x[c*W_X +: W_X] = W_X'($urandom);
         b0 = beats;
         start_job(x);
         wait_idle(200, 70, ok);
         checks++;
         if (!ok || beats - b0 != T || sbq.size() != 0) begin
            errors++;
            $display("FAIL random_%0d: got idle=%b beats=%0d pending=%0d expected 1 %0d 0",
                     j, ok, beats - b0, sbq.size(), T);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_extremes();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
